// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: 1 us timebase, shared frame counter,
// per-channel pulse widths double-buffered and swapped at frame boundaries.
module servo_pwm_multi #(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 50,
    parameter int PERIOD_US  = 20000,
    parameter int MIN_US     = 500,
    parameter int MAX_US     = 2500,
    parameter int W          = 12,
    parameter int LED_FRAMES = 25
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      enable,
    input  logic                                      wr_en,
    input  logic [$clog2(N_CH > 1 ? N_CH : 2)-1:0]   ch_sel,
    input  logic [W-1:0]                              pulse_us,
    output logic [N_CH-1:0]                           pwm,
    output logic                                      frame_start,
    output logic                                      led
);

    localparam int CW   = $clog2(N_CH > 1 ? N_CH : 2);
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int UW   = $clog2(PERIOD_US);
    localparam int LW   = (LED_FRAMES > 1) ? $clog2(LED_FRAMES) : 1;
    localparam int CMPW = (UW > W) ? UW : W;

    generate
        if (PERIOD_US <= MAX_US) begin : g_bad_period
            $error("servo_pwm_multi: PERIOD_US must be greater than MAX_US");
        end
    endgenerate

    logic [PW-1:0] presc;
    logic [UW-1:0] us_cnt;
    logic [LW-1:0] led_cnt;
    logic [W-1:0]  shadow [N_CH];
    logic [W-1:0]  active [N_CH];
    logic [W-1:0]  wr_val;
    logic          tick;
    logic          boundary;

    assign tick     = (presc == PW'(TICK_DIV - 1));
    assign boundary = tick && (us_cnt == UW'(PERIOD_US - 1));

    // Nonzero requests are clamped into the servo's safe range; zero means off.
    always_comb begin
        wr_val = pulse_us;
        if (pulse_us == '0) begin
            wr_val = '0;
        end else if (pulse_us < W'(MIN_US)) begin
            wr_val = W'(MIN_US);
        end else if (pulse_us > W'(MAX_US)) begin
            wr_val = W'(MAX_US);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc       <= '0;
            us_cnt      <= '0;
            led_cnt     <= '0;
            led         <= 1'b0;
            frame_start <= 1'b0;
        end else if (!enable) begin
            presc       <= '0;
            us_cnt      <= '0;
            led_cnt     <= '0;
            frame_start <= 1'b0;
        end else begin
            presc       <= tick ? '0 : presc + PW'(1);
            frame_start <= boundary;
            if (tick) begin
                us_cnt <= boundary ? '0 : us_cnt + UW'(1);
            end
            if (boundary) begin
                if (led_cnt == LW'(LED_FRAMES - 1)) begin
                    led_cnt <= '0;
                    led     <= ~led;
                end else begin
                    led_cnt <= led_cnt + LW'(1);
                end
            end
        end
    end

    // While stopped the active set tracks shadow so new widths apply at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            pwm <= '0;
        end else begin
            if (wr_en && (int'(ch_sel) < N_CH)) begin
                shadow[ch_sel] <= wr_val;
            end
            for (int i = 0; i < N_CH; i++) begin
                if (!enable || boundary) begin
                    active[i] <= shadow[i];
                end
                pwm[i] <= enable && (CMPW'(us_cnt) < CMPW'(active[i]));
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Self-checking bench for servo_pwm_multi: clock-position reference model
// compared every cycle, directed frame measurements, then random traffic.
module tb_servo_pwm_multi;

    // Three channels so that ch_sel=3 is a representable out-of-range address.
    localparam int N_CH       = 3;
    localparam int TICK_DIV   = 4;
    localparam int PERIOD_US  = 100;
    localparam int MIN_US     = 5;
    localparam int MAX_US     = 50;
    localparam int W          = 12;
    localparam int LED_FRAMES = 2;
    localparam int FRAME_CLK  = PERIOD_US * TICK_DIV;

    logic            clk;
    logic            reset;
    logic            enable;
    logic            wr_en;
    logic [1:0]      ch_sel;
    logic [W-1:0]    pulse_us;
    logic [N_CH-1:0] pwm;
    logic            frame_start;
    logic            led;

    int test_count = 0;
    int fail_count = 0;

    servo_pwm_multi #(
        .N_CH(N_CH), .TICK_DIV(TICK_DIV), .PERIOD_US(PERIOD_US), .MIN_US(MIN_US),
        .MAX_US(MAX_US), .W(W), .LED_FRAMES(LED_FRAMES)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .ch_sel(ch_sel),
        .pulse_us(pulse_us), .pwm(pwm), .frame_start(frame_start), .led(led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: position in the frame counted in clocks since the frame began.
    int              m_shadow [N_CH];
    int              m_active [N_CH];
    int              m_pos;
    int              m_frames;
    logic [N_CH-1:0] m_pwm;
    logic            m_fs;
    logic            m_led;

    function automatic int clampUs(input int v);
        if (v == 0) return 0;
        if (v < MIN_US) return MIN_US;
        if (v > MAX_US) return MAX_US;
        return v;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                m_shadow[i] = 0;
                m_active[i] = 0;
            end
            m_pos = 0; m_frames = 0; m_pwm = '0; m_fs = 1'b0; m_led = 1'b0;
        end else begin
            if (!enable) begin
                m_pwm = '0; m_fs = 1'b0; m_pos = 0; m_frames = 0;
                for (int i = 0; i < N_CH; i++) m_active[i] = m_shadow[i];
            end else begin
                for (int i = 0; i < N_CH; i++) m_pwm[i] = (m_pos < m_active[i] * TICK_DIV);
                m_fs = (m_pos == FRAME_CLK - 1);
                if (m_fs) begin
                    for (int i = 0; i < N_CH; i++) m_active[i] = m_shadow[i];
                    m_frames++;
                    if (m_frames == LED_FRAMES) begin
                        m_frames = 0;
                        m_led = !m_led;
                    end
                end
                m_pos = (m_pos + 1) % FRAME_CLK;
            end
            if (wr_en && (int'(ch_sel) < N_CH)) m_shadow[ch_sel] = clampUs(int'(pulse_us));
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        test_count++;
        if (actual != expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("model_pwm", int'(pwm), int'(m_pwm));
            checkOutput("model_frame_start", int'(frame_start), int'(m_fs));
            checkOutput("model_led", int'(led), int'(m_led));
        end
    end

    task automatic applyStimulus(input int ch, input int val);
        wr_en    = 1'b1;
        ch_sel   = 2'(ch);
        pulse_us = W'(val);
        @(negedge clk);
        wr_en    = 1'b0;
    endtask

    task automatic waitNextFrameStart(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_start && k < 1000);
        if (!frame_start) checkOutput("frame_start_timeout", k, -1);
    endtask

    // Counts high clocks per channel from the current/next frame_start to the following one.
    task automatic measureFrame(output int hi0, output int hi1, output int hi2, output int len);
        int k;
        hi0 = 0; hi1 = 0; hi2 = 0; len = 0;
        k = 0;
        while (!frame_start && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (!frame_start) begin
            checkOutput("measure_timeout", k, -1);
            return;
        end
        do begin
            @(negedge clk);
            len++;
            hi0 += int'(pwm[0]);
            hi1 += int'(pwm[1]);
            hi2 += int'(pwm[2]);
        end while (!frame_start && len < 1000);
    endtask

    initial begin
        int h0, h1, h2, len, k;
        int led_exp [4] = '{0, 1, 1, 0};

        reset = 1'b1; enable = 1'b0; wr_en = 1'b0; ch_sel = '0; pulse_us = '0;
        #1;
        checkOutput("reset_pwm", int'(pwm), 0);
        checkOutput("reset_frame_start", int'(frame_start), 0);
        checkOutput("reset_led", int'(led), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Widths written while stopped, then run.
        applyStimulus(0, 10);
        applyStimulus(1, 20);
        applyStimulus(2, 7);
        enable = 1'b1;
        measureFrame(h0, h1, h2, len);
        checkOutput("t1_ch0_high", h0, 40);
        checkOutput("t1_ch1_high", h1, 80);
        checkOutput("t1_ch2_high", h2, 28);
        checkOutput("t1_frame_len", len, 400);

        // Clamping of low, high and zero requests.
        applyStimulus(0, 3);
        measureFrame(h0, h1, h2, len);
        checkOutput("t2_ch0_min", h0, 20);
        applyStimulus(0, 80);
        measureFrame(h0, h1, h2, len);
        checkOutput("t2_ch0_max", h0, 200);
        applyStimulus(0, 0);
        measureFrame(h0, h1, h2, len);
        checkOutput("t2_ch0_off", h0, 0);

        // Write landing on the boundary clock takes effect one frame later.
        repeat (399) @(negedge clk);
        applyStimulus(1, 30);
        checkOutput("t3_fs_at_write", int'(frame_start), 1);
        measureFrame(h0, h1, h2, len);
        checkOutput("t3_ch1_old", h1, 80);
        measureFrame(h0, h1, h2, len);
        checkOutput("t3_ch1_new", h1, 120);

        // Out-of-range channel is ignored.
        applyStimulus(3, 40);
        measureFrame(h0, h1, h2, len);
        checkOutput("t4_ch0", h0, 0);
        checkOutput("t4_ch1", h1, 120);
        checkOutput("t4_ch2", h2, 28);

        // Stop mid-pulse, write while stopped, restart.
        repeat (10) @(negedge clk);
        checkOutput("t5_pwm_before_stop", int'(pwm), 3'b110);
        enable = 1'b0;
        @(negedge clk);
        checkOutput("t5_pwm_stopped", int'(pwm), 0);
        applyStimulus(0, 9);
        repeat (4) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        checkOutput("t5_pwm_restart", int'(pwm), 3'b111);
        k = 1;
        while (!frame_start && k < 1000) begin
            @(negedge clk);
            k++;
        end
        checkOutput("t5_first_fs_delay", k, 400);

        // Reset mid-pulse with the LED lit.
        for (int f = 0; f < 6; f++) begin
            waitNextFrameStart(k);
            repeat (5) @(negedge clk);
            if (led) break;
        end
        checkOutput("t6_led_before", int'(led), 1);
        checkOutput("t6_pwm_before", int'(pwm), 3'b111);
        #2 reset = 1'b1;
        #1;
        checkOutput("t6_pwm_reset", int'(pwm), 0);
        checkOutput("t6_led_reset", int'(led), 0);
        checkOutput("t6_fs_reset", int'(frame_start), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int f = 0; f < 4; f++) begin
            waitNextFrameStart(k);
            checkOutput("t6_led_frame", int'(led), led_exp[f]);
            checkOutput("t6_pwm_cleared", int'(pwm), 0);
        end

        // Random writes and enable drops, checked by the model every cycle.
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            wr_en  = ($urandom_range(0, 19) == 0);
            ch_sel = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       pulse_us = '0;
                1:       pulse_us = W'($urandom_range(1, MIN_US - 1));
                2:       pulse_us = W'($urandom_range(MIN_US, MAX_US));
                default: pulse_us = W'($urandom_range(MAX_US + 1, 4095));
            endcase
            if ($urandom_range(0, 599) == 0) enable = !enable;
        end
        @(negedge clk);
        wr_en = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
